rice_core_trap_ctrl: RTL and testbench

Machine-mode trap controller for the rice core. It takes exceptions and interrupts, arbitrates between them, and tracks the privilege level. It handles MRET and WFI sleep, and generates the mstatus/mepc/mcause/mtval update strobes for the M-level CSR block. Direct and vectored mtvec modes are supported. The block sits between the retire stage and the CSR block; the fetch stage consumes its trap/return redirects.

---
 rtl/rice_core_pkg.sv | 18 +
 rtl/rice_sync_ff.sv | 30 +++
 rtl/rice_core_trap_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_rice_core_trap_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rice_core_pkg.sv
// Shared definitions for the rice core: privilege encodings,
// interrupt cause codes and the trap controller state type.
package rice_core_pkg;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MEI = 11;

    typedef enum logic [1:0] {
        RUN,
        SLEEP,
        REDIRECT
    } rice_core_trap_state;

endpackage

// File: rtl/rice_sync_ff.sv
// Single-bit flop-chain synchroniser; STAGES=0 degenerates to a wire.
module rice_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    if (STAGES == 0) begin : g_bypass
        assign o_q = i_d;
    end else begin : g_chain
        logic [STAGES-1:0] q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                q <= '0;
            end else begin
                q[0] <= i_d;
                for (int i = 1; i < STAGES; i++) begin
                    q[i] <= q[i-1];
                end
            end
        end

        assign o_q = q[STAGES-1];
    end

endmodule

// File: rtl/rice_core_trap_ctrl.sv
// Machine-mode trap controller: exception/interrupt arbitration,
// MRET, WFI sleep and M-level CSR update strobes.
module rice_core_trap_ctrl
    import rice_core_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int EXCEPTION_WIDTH = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int VECTORED        = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic                       i_retire_valid,
    input  logic [XLEN-1:0]            i_retire_pc,
    input  logic [XLEN-1:0]            i_retire_next_pc,
    input  logic [EXCEPTION_WIDTH-1:0] i_exception,
    input  logic [XLEN-1:0]            i_tval,
    input  logic                       i_mret,
    input  logic                       i_wfi,
    input  logic                       i_irq_software,
    input  logic                       i_irq_timer,
    input  logic                       i_irq_external,
    input  logic                       i_mstatus_mie,
    input  logic                       i_mstatus_mpie,
    input  logic [1:0]                 i_mstatus_mpp,
    input  logic [2:0]                 i_mie,
    input  logic [XLEN-3:0]            i_mtvec_base,
    input  logic [1:0]                 i_mtvec_mode,
    input  logic [XLEN-1:0]            i_mepc,
    output logic [1:0]                 o_privilege_level,
    output logic [2:0]                 o_mip,
    output logic                       o_trap_valid,
    output logic [XLEN-1:0]            o_trap_pc,
    output logic                       o_return_valid,
    output logic [XLEN-1:0]            o_return_pc,
    output logic                       o_sleep,
    output logic                       o_mstatus_set,
    output logic                       o_mstatus_mie,
    output logic                       o_mstatus_mpie,
    output logic [1:0]                 o_mstatus_mpp,
    output logic                       o_mepc_set,
    output logic [XLEN-1:0]            o_mepc,
    output logic                       o_mcause_set,
    output logic                       o_mcause_interrupt,
    output logic [XLEN-2:0]            o_mcause_code,
    output logic                       o_mtval_set,
    output logic [XLEN-1:0]            o_mtval
);

    localparam int CW = XLEN - 1;

    rice_core_trap_state state_q, state_d;
    logic [1:0]      priv_q, priv_d;
    logic [1:0]      swtm_q;
    logic            meip;
    logic [2:0]      pend;
    logic            taken;
    logic [CW-1:0]   irq_code, exc_code;
    logic [XLEN-1:0] wfi_pc_q, wfi_pc_d;

    logic            trap_q, trap_d, ret_q, ret_d;
    logic            mst_set_q, mst_set_d, mepc_set_q, mepc_set_d;
    logic            mcause_set_q, mcause_set_d, mtval_set_q, mtval_set_d;
    logic            mie_q, mie_d, mpie_q, mpie_d, irq_q, irq_d;
    logic [1:0]      mpp_q, mpp_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d, ret_pc_q, ret_pc_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mtval_q, mtval_d;
    logic [CW-1:0]   code_q, code_d;

    logic            do_trap, trap_irq, vec;
    logic [CW-1:0]   trap_code;
    logic [XLEN-1:0] trap_epc, trap_tval;

    rice_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_meip (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_irq_external),
        .o_q    (meip)
    );

    assign o_mip = {meip, swtm_q};
    assign pend  = o_mip & i_mie;
    assign taken = (|pend) && (i_mstatus_mie || priv_q != PRIV_M);

    // Fixed priority MEI > MSI > MTI.
    assign irq_code = pend[2] ? CW'(IRQ_MEI) :
                      pend[0] ? CW'(IRQ_MSI) : CW'(IRQ_MTI);

    always_comb begin
        exc_code = '0;
        for (int i = EXCEPTION_WIDTH - 1; i >= 0; i--) begin
            if (i_exception[i]) exc_code = CW'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        priv_d       = priv_q;
        wfi_pc_d     = wfi_pc_q;
        trap_d       = 1'b0;
        ret_d        = 1'b0;
        mst_set_d    = 1'b0;
        mepc_set_d   = 1'b0;
        mcause_set_d = 1'b0;
        mtval_set_d  = 1'b0;
        mie_d        = mie_q;
        mpie_d       = mpie_q;
        mpp_d        = mpp_q;
        irq_d        = irq_q;
        code_d       = code_q;
        trap_pc_d    = trap_pc_q;
        ret_pc_d     = ret_pc_q;
        mepc_d       = mepc_q;
        mtval_d      = mtval_q;
        do_trap      = 1'b0;
        trap_irq     = 1'b0;
        trap_code    = '0;
        trap_epc     = '0;
        trap_tval    = '0;

        if (!i_enable) begin
            state_d = RUN;
            priv_d  = PRIV_M;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (i_retire_valid) begin
                        if (|i_exception) begin
                            do_trap   = 1'b1;
                            trap_code = exc_code;
                            trap_epc  = i_retire_pc;
                            trap_tval = (exc_code < CW'(8)) ? i_tval : '0;
                        end else if (taken) begin
                            do_trap   = 1'b1;
                            trap_irq  = 1'b1;
                            trap_code = irq_code;
                            trap_epc  = i_retire_next_pc;
                        end else if (i_mret) begin
                            state_d   = REDIRECT;
                            ret_d     = 1'b1;
                            ret_pc_d  = i_mepc;
                            mst_set_d = 1'b1;
                            mie_d     = i_mstatus_mpie;
                            mpie_d    = 1'b1;
                            mpp_d     = PRIV_U;
                            priv_d    = i_mstatus_mpp;
                        end else if (i_wfi) begin
                            state_d  = SLEEP;
                            wfi_pc_d = i_retire_next_pc;
                        end
                    end
                end
                SLEEP: begin
                    // Any enabled pending source wakes, even with MIE clear.
                    if (|pend) begin
                        if (taken) begin
                            do_trap   = 1'b1;
                            trap_irq  = 1'b1;
                            trap_code = irq_code;
                            trap_epc  = wfi_pc_q;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                REDIRECT: state_d = RUN;
                default:  state_d = RUN;
            endcase

            if (do_trap) begin
                vec          = (VECTORED != 0) && (i_mtvec_mode == 2'b01);
                state_d      = REDIRECT;
                trap_d       = 1'b1;
                trap_pc_d    = {i_mtvec_base, 2'b00} +
                               ((vec && trap_irq) ? XLEN'({trap_code, 2'b00}) : '0);
                mst_set_d    = 1'b1;
                mie_d        = 1'b0;
                mpie_d       = i_mstatus_mie;
                mpp_d        = priv_q;
                priv_d       = PRIV_M;
                mepc_set_d   = 1'b1;
                mepc_d       = trap_epc;
                mcause_set_d = 1'b1;
                irq_d        = trap_irq;
                code_d       = trap_code;
                mtval_set_d  = 1'b1;
                mtval_d      = trap_tval;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= RUN;
            priv_q       <= PRIV_M;
            swtm_q       <= '0;
            wfi_pc_q     <= '0;
            trap_q       <= 1'b0;
            ret_q        <= 1'b0;
            mst_set_q    <= 1'b0;
            mepc_set_q   <= 1'b0;
            mcause_set_q <= 1'b0;
            mtval_set_q  <= 1'b0;
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            mpp_q        <= '0;
            irq_q        <= 1'b0;
            code_q       <= '0;
            trap_pc_q    <= '0;
            ret_pc_q     <= '0;
            mepc_q       <= '0;
            mtval_q      <= '0;
        end else begin
            state_q      <= state_d;
            priv_q       <= priv_d;
            swtm_q       <= {i_irq_timer, i_irq_software};
            wfi_pc_q     <= wfi_pc_d;
            trap_q       <= trap_d;
            ret_q        <= ret_d;
            mst_set_q    <= mst_set_d;
            mepc_set_q   <= mepc_set_d;
            mcause_set_q <= mcause_set_d;
            mtval_set_q  <= mtval_set_d;
            mie_q        <= mie_d;
            mpie_q       <= mpie_d;
            mpp_q        <= mpp_d;
            irq_q        <= irq_d;
            code_q       <= code_d;
            trap_pc_q    <= trap_pc_d;
            ret_pc_q     <= ret_pc_d;
            mepc_q       <= mepc_d;
            mtval_q      <= mtval_d;
        end
    end

    // Disable drops an in-flight redirect at once, not a cycle later.
    assign o_privilege_level  = i_enable ? priv_q : PRIV_M;
    assign o_sleep            = i_enable && (state_q == SLEEP);
    assign o_trap_valid       = trap_q & i_enable;
    assign o_return_valid     = ret_q & i_enable;
    assign o_mstatus_set      = mst_set_q & i_enable;
    assign o_mepc_set         = mepc_set_q & i_enable;
    assign o_mcause_set       = mcause_set_q & i_enable;
    assign o_mtval_set        = mtval_set_q & i_enable;
    assign o_trap_pc          = trap_pc_q;
    assign o_return_pc        = ret_pc_q;
    assign o_mstatus_mie      = mie_q;
    assign o_mstatus_mpie     = mpie_q;
    assign o_mstatus_mpp      = mpp_q;
    assign o_mepc             = mepc_q;
    assign o_mcause_interrupt = irq_q;
    assign o_mcause_code      = code_q;
    assign o_mtval            = mtval_q;

endmodule

// File: tb/tb_rice_core_trap_ctrl.sv
// Bench for rice_core_trap_ctrl: directed scenarios plus random
// traffic checked every cycle against a behavioural model.
module tb_rice_core_trap_ctrl;

    localparam int SYNC = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable, i_retire_valid, i_mret, i_wfi;
    logic [31:0] i_retire_pc, i_retire_next_pc, i_tval, i_mepc;
    logic [15:0] i_exception;
    logic        i_irq_software, i_irq_timer, i_irq_external;
    logic        i_mstatus_mie, i_mstatus_mpie;
    logic [1:0]  i_mstatus_mpp, i_mtvec_mode;
    logic [2:0]  i_mie;
    logic [29:0] i_mtvec_base;

    logic [1:0]  o_privilege_level, o_mstatus_mpp;
    logic [2:0]  o_mip;
    logic        o_trap_valid, o_return_valid, o_sleep;
    logic        o_mstatus_set, o_mstatus_mie, o_mstatus_mpie;
    logic        o_mepc_set, o_mcause_set, o_mcause_interrupt, o_mtval_set;
    logic [31:0] o_trap_pc, o_return_pc, o_mepc, o_mtval;
    logic [30:0] o_mcause_code;

    always #5 i_clk = ~i_clk;

    rice_core_trap_ctrl #(
        .XLEN(32), .EXCEPTION_WIDTH(16), .SYNC_STAGES(SYNC), .VECTORED(1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_retire_valid(i_retire_valid), .i_retire_pc(i_retire_pc),
        .i_retire_next_pc(i_retire_next_pc), .i_exception(i_exception),
        .i_tval(i_tval), .i_mret(i_mret), .i_wfi(i_wfi),
        .i_irq_software(i_irq_software), .i_irq_timer(i_irq_timer),
        .i_irq_external(i_irq_external), .i_mstatus_mie(i_mstatus_mie),
        .i_mstatus_mpie(i_mstatus_mpie), .i_mstatus_mpp(i_mstatus_mpp),
        .i_mie(i_mie), .i_mtvec_base(i_mtvec_base),
        .i_mtvec_mode(i_mtvec_mode), .i_mepc(i_mepc),
        .o_privilege_level(o_privilege_level), .o_mip(o_mip),
        .o_trap_valid(o_trap_valid), .o_trap_pc(o_trap_pc),
        .o_return_valid(o_return_valid), .o_return_pc(o_return_pc),
        .o_sleep(o_sleep), .o_mstatus_set(o_mstatus_set),
        .o_mstatus_mie(o_mstatus_mie), .o_mstatus_mpie(o_mstatus_mpie),
        .o_mstatus_mpp(o_mstatus_mpp), .o_mepc_set(o_mepc_set),
        .o_mepc(o_mepc), .o_mcause_set(o_mcause_set),
        .o_mcause_interrupt(o_mcause_interrupt),
        .o_mcause_code(o_mcause_code), .o_mtval_set(o_mtval_set),
        .o_mtval(o_mtval)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Model: mode 0 running, 1 asleep, 2 redirecting.
    int          m_mode;
    logic [1:0]  m_priv;
    logic [1:0]  m_swtm;
    logic        m_meip;
    bit          ext_hist[$];
    logic [31:0] m_wake_pc;
    bit          e_trap, e_ret, e_mst, e_mepc_set, e_mcause_set, e_mtval_set;
    bit          e_mie, e_mpie, e_irq;
    logic [1:0]  e_mpp;
    int          e_code;
    logic [31:0] e_trap_pc, e_ret_pc, e_mepc, e_mtval;

    task automatic model_reset();
        m_mode = 0; m_priv = 2'b11; m_swtm = 0; m_meip = 0;
        ext_hist.delete(); m_wake_pc = 0;
        e_trap = 0; e_ret = 0; e_mst = 0;
        e_mepc_set = 0; e_mcause_set = 0; e_mtval_set = 0;
        e_mie = 0; e_mpie = 0; e_irq = 0; e_mpp = 0; e_code = 0;
        e_trap_pc = 0; e_ret_pc = 0; e_mepc = 0; e_mtval = 0;
    endtask

    task automatic model_step();
        logic [2:0]  pend;
        bit          take, trap, irq;
        int          code;
        logic [31:0] epc, tval;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        pend = {m_meip, m_swtm} & i_mie;
        take = (pend != 0) && (i_mstatus_mie || m_priv != 2'b11);
        e_trap = 0; e_ret = 0; e_mst = 0;
        e_mepc_set = 0; e_mcause_set = 0; e_mtval_set = 0;
        trap = 0; irq = 0; code = 0; epc = 0; tval = 0;
        if (!i_enable) begin
            m_mode = 0;
            m_priv = 2'b11;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (pend != 0) begin
                if (take) begin trap = 1; irq = 1; epc = m_wake_pc; end
                else m_mode = 0;
            end
        end else if (i_retire_valid) begin
            if (i_exception != 0) begin
                trap = 1;
                while (!i_exception[code]) code++;
                epc  = i_retire_pc;
                tval = (code < 8) ? i_tval : 32'h0;
            end else if (take) begin
                trap = 1; irq = 1; epc = i_retire_next_pc;
            end else if (i_mret) begin
                e_ret = 1; e_ret_pc = i_mepc; e_mst = 1;
                e_mie = i_mstatus_mpie; e_mpie = 1; e_mpp = 0;
                m_priv = i_mstatus_mpp; m_mode = 2;
            end else if (i_wfi) begin
                m_mode = 1; m_wake_pc = i_retire_next_pc;
            end
        end
        if (trap) begin
            if (irq) code = pend[2] ? 11 : (pend[0] ? 3 : 7);
            e_trap = 1;
            e_trap_pc = {i_mtvec_base, 2'b00} +
                        ((irq && i_mtvec_mode == 2'd1) ? 32'(4 * code) : 32'h0);
            e_mst = 1; e_mie = 0; e_mpie = i_mstatus_mie; e_mpp = m_priv;
            e_mepc_set = 1; e_mepc = epc;
            e_mcause_set = 1; e_irq = irq; e_code = code;
            e_mtval_set = 1; e_mtval = tval;
            m_priv = 2'b11; m_mode = 2;
        end
        ext_hist.push_back(i_irq_external);
        m_meip = 0;
        if (ext_hist.size() == SYNC) m_meip = ext_hist.pop_front();
        m_swtm = {i_irq_timer, i_irq_software};
    endtask

    task automatic compare_all();
        bit en;
        en = i_enable;
        chk("priv", o_privilege_level, en ? m_priv : 2'b11);
        chk("mip", o_mip, {m_meip, m_swtm});
        chk("trap_valid", o_trap_valid, e_trap & en);
        chk("return_valid", o_return_valid, e_ret & en);
        chk("sleep", o_sleep, (m_mode == 1) & en);
        chk("mstatus_set", o_mstatus_set, e_mst & en);
        chk("mepc_set", o_mepc_set, e_mepc_set & en);
        chk("mcause_set", o_mcause_set, e_mcause_set & en);
        chk("mtval_set", o_mtval_set, e_mtval_set & en);
        if (e_trap && en) chk("trap_pc", o_trap_pc, e_trap_pc);
        if (e_ret && en) chk("return_pc", o_return_pc, e_ret_pc);
        if (e_mst && en) begin
            chk("mst_fields", {o_mstatus_mie, o_mstatus_mpie, o_mstatus_mpp},
                {e_mie, e_mpie, e_mpp});
        end
        if (e_mepc_set && en) chk("mepc", o_mepc, e_mepc);
        if (e_mcause_set && en) begin
            chk("mcause", {o_mcause_interrupt, o_mcause_code},
                {e_irq, 31'(e_code)});
        end
        if (e_mtval_set && en) chk("mtval", o_mtval, e_mtval);
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        compare_all();
    endtask

    initial begin
        int n;
        i_enable = 1; i_retire_valid = 0; i_mret = 0; i_wfi = 0;
        i_retire_pc = 0; i_retire_next_pc = 0; i_tval = 0; i_mepc = 0;
        i_exception = 0; i_irq_software = 0; i_irq_timer = 0;
        i_irq_external = 0; i_mstatus_mie = 0; i_mstatus_mpie = 0;
        i_mstatus_mpp = 0; i_mtvec_mode = 0; i_mie = 0; i_mtvec_base = 0;
        model_reset();
        repeat (2) @(negedge i_clk);
        chk("rst_priv", o_privilege_level, 2'b11);
        chk("rst_trap", o_trap_valid, 0);
        chk("rst_sleep", o_sleep, 0);
        chk("rst_mip", o_mip, 0);
        i_rst_n = 1;
        cycle();

        // Illegal instruction, direct mode
        i_mstatus_mie = 1; i_mtvec_base = 30'h80; i_mtvec_mode = 0;
        i_retire_valid = 1; i_exception = 16'h0004;
        i_retire_pc = 32'h100; i_retire_next_pc = 32'h104; i_tval = 32'hDEAD;
        cycle();
        chk("ill_pc", o_trap_pc, 32'h200);
        chk("ill_code", o_mcause_code, 2);
        chk("ill_mepc", o_mepc, 32'h100);
        chk("ill_mtval", o_mtval, 32'hDEAD);
        chk("ill_mie", o_mstatus_mie, 0);
        chk("ill_mpie", o_mstatus_mpie, 1);
        i_retire_valid = 0; i_exception = 0;
        repeat (2) cycle();

        // Vectored timer interrupt
        i_mie = 3'b010; i_irq_timer = 1;
        cycle();
        i_mtvec_base = 30'h100; i_mtvec_mode = 1;
        i_retire_valid = 1; i_retire_next_pc = 32'h84;
        cycle();
        chk("vt_pc", o_trap_pc, 32'h41C);
        chk("vt_irq", o_mcause_interrupt, 1);
        chk("vt_code", o_mcause_code, 7);
        chk("vt_mepc", o_mepc, 32'h84);
        i_retire_valid = 0; i_irq_timer = 0; i_mtvec_mode = 0;
        repeat (2) cycle();

        // Exception beats interrupts, then MEI beats MSI
        i_mie = 3'b101; i_irq_software = 1; i_irq_external = 1;
        repeat (3) cycle();
        i_retire_valid = 1; i_exception = 16'h0800;
        i_retire_pc = 32'h140; i_retire_next_pc = 32'h144;
        cycle();
        chk("sim_code", o_mcause_code, 11);
        chk("sim_irq", o_mcause_interrupt, 0);
        i_retire_valid = 0; i_exception = 0;
        cycle();
        i_retire_valid = 1;
        cycle();
        chk("mei_code", o_mcause_code, 11);
        chk("mei_irq", o_mcause_interrupt, 1);
        chk("mei_mepc", o_mepc, 32'h144);
        i_retire_valid = 0; i_irq_software = 0; i_irq_external = 0; i_mie = 0;
        repeat (3) cycle();

        // MRET to user mode
        i_mstatus_mpp = 0; i_mstatus_mpie = 1; i_mepc = 32'h300;
        i_mret = 1; i_retire_valid = 1;
        cycle();
        chk("ret_pc", o_return_pc, 32'h300);
        chk("ret_priv", o_privilege_level, 0);
        chk("ret_mst", {o_mstatus_mie, o_mstatus_mpie, o_mstatus_mpp}, 4'b1100);
        i_mret = 0; i_retire_valid = 0;
        cycle();
        i_retire_valid = 1; i_exception = 16'h0008;
        cycle();
        i_retire_valid = 0; i_exception = 0;
        cycle();
        chk("back_m", o_privilege_level, 2'b11);

        // WFI wake without trap, then with trap
        i_mstatus_mie = 0; i_mie = 3'b100;
        i_retire_valid = 1; i_wfi = 1;
        i_retire_pc = 32'h500; i_retire_next_pc = 32'h504;
        cycle();
        chk("wfi_sleep", o_sleep, 1);
        i_retire_valid = 0; i_wfi = 0; i_irq_external = 1;
        n = 0;
        do begin cycle(); n++; end while (o_sleep && n < 10);
        chk("wake_lat", n, SYNC + 1);
        chk("wake_notrap", o_trap_valid, 0);
        i_irq_external = 0;
        repeat (3) cycle();
        i_mstatus_mie = 1; i_retire_valid = 1; i_wfi = 1;
        i_retire_pc = 32'h600; i_retire_next_pc = 32'h604;
        cycle();
        i_retire_valid = 0; i_wfi = 0; i_irq_external = 1;
        n = 0;
        do begin cycle(); n++; end while (!o_trap_valid && n < 10);
        chk("wfi_trap_lat", n, SYNC + 1);
        chk("wfi_mepc", o_mepc, 32'h604);
        chk("wfi_code", o_mcause_code, 11);
        i_irq_external = 0; i_mie = 0;
        repeat (3) cycle();

        // Disable during REDIRECT and during SLEEP
        i_retire_valid = 1; i_exception = 16'h0002; i_retire_pc = 32'h700;
        cycle();
        chk("redir_pre", o_trap_valid, 1);
        i_retire_valid = 0; i_exception = 0; i_enable = 0;
        #1;
        chk("dis_trap", o_trap_valid, 0);
        chk("dis_mepc_set", o_mepc_set, 0);
        chk("dis_priv", o_privilege_level, 2'b11);
        cycle();
        i_enable = 1;
        cycle();
        i_retire_valid = 1; i_wfi = 1;
        cycle();
        chk("sl_pre", o_sleep, 1);
        i_retire_valid = 0; i_wfi = 0; i_enable = 0;
        #1;
        chk("dis_sleep", o_sleep, 0);
        cycle();
        i_enable = 1;
        cycle();
        chk("dis_run", o_sleep, 0);

        // Asynchronous reset in the middle of a trap
        i_retire_valid = 1; i_exception = 16'h0004;
        cycle();
        i_retire_valid = 0; i_exception = 0;
        #2 i_rst_n = 0;
        #1;
        chk("ar_trap", o_trap_valid, 0);
        chk("ar_strobes", {o_mstatus_set, o_mepc_set, o_mcause_set, o_mtval_set}, 0);
        chk("ar_data", {o_trap_pc, o_mepc}, 0);
        chk("ar_code", o_mcause_code, 0);
        chk("ar_priv", o_privilege_level, 2'b11);
        model_reset();
        cycle();
        i_rst_n = 1;
        cycle();

        // Random traffic against the model
        repeat (600) begin
            i_enable         = ($urandom_range(0, 19) != 0);
            i_retire_valid   = ($urandom_range(0, 2) != 0);
            i_exception      = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
            i_retire_pc      = $urandom;
            i_retire_next_pc = i_retire_pc + 32'd4;
            i_tval           = $urandom;
            i_mret           = ($urandom_range(0, 7) == 0);
            i_wfi            = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) i_irq_software = ~i_irq_software;
            if ($urandom_range(0, 9) == 0) i_irq_timer = ~i_irq_timer;
            if ($urandom_range(0, 9) == 0) i_irq_external = ~i_irq_external;
            i_mstatus_mie    = 1'($urandom);
            i_mstatus_mpie   = 1'($urandom);
            i_mstatus_mpp    = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            i_mie            = 3'($urandom);
            i_mtvec_base     = 30'($urandom);
            i_mtvec_mode     = 2'($urandom);
            i_mepc           = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
